// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexes one hex code bus across NUM_DIGITS digits with blanking gaps.
//  clk, reset          rising-edge clock, synchronous active-high reset
//  load, value, lz_en  strobe a new display word and leading-zero mode into the shadow
//  digit_code          4-bit code of the digit being driven
//  digit_en            one-hot digit drive, zero while blanked or suppressed
//  frame_start         pulse on the cycle digit 0 starts (shadow copied if pending)
//  pending             shadow holds a word not yet shown
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SHOW_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    lz_en,
  output logic [3:0]              digit_code,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_start,
  output logic                    pending
);
  localparam int MAXC = SHOW_CYCLES > BLANK_CYCLES ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int CW   = MAXC > 1 ? $clog2(MAXC) : 1;
  localparam int IW   = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  typedef enum logic {BLANK, SHOW} state_t;
  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d, nxt;
  logic                    first_q, first_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d, shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   supp_q, supp_d, supp_sh, en_q, en_d;
  logic                    lz_q, lz_d, fs_q, fs_d, pend_q, pend_d, allz;
  logic [3:0]              code_q, code_d;
  assign digit_code  = code_q;
  assign digit_en    = en_q;
  assign frame_start = fs_q;
  assign pending     = pend_q;
  // a digit is suppressed when it and every more significant digit are zero
  always_comb begin
    allz    = 1'b1;
    supp_sh = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      allz       = allz & (shadow_q[4*i +: 4] == 4'h0);
      supp_sh[i] = lz_q & allz;
    end
  end
  // the very first digit after reset is digit 0, not idx+1
  assign nxt = first_q ? '0 : (idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + IW'(1));
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    idx_d    = idx_q;
    first_d  = first_q;
    active_d = active_q;
    supp_d   = supp_q;
    shadow_d = shadow_q;
    lz_d     = lz_q;
    pend_d   = pend_q;
    code_d   = code_q;
    en_d     = en_q;
    fs_d     = 1'b0;
    if (state_q == BLANK) begin
      if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
        cnt_d   = '0;
        state_d = SHOW;
        idx_d   = nxt;
        first_d = 1'b0;
        if (nxt == '0) begin
          fs_d = 1'b1;
          if (pend_q) begin
            active_d = shadow_q;
            supp_d   = supp_sh;
            pend_d   = 1'b0;
          end
        end
        code_d = active_d[4*nxt +: 4];
        en_d   = (NUM_DIGITS'(1) << nxt) & ~supp_d;
      end
    end else if (cnt_q == CW'(SHOW_CYCLES - 1)) begin
      cnt_d   = '0;
      state_d = BLANK;
      en_d    = '0;
    end
    // a load on the boundary cycle lands after the copy and stays pending
    if (load) begin
      shadow_d = value;
      lz_d     = lz_en;
      pend_d   = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= BLANK;
      cnt_q    <= '0;
      idx_q    <= '0;
      first_q  <= 1'b1;
      active_q <= '0;
      supp_q   <= '0;
      shadow_q <= '0;
      lz_q     <= 1'b0;
      pend_q   <= 1'b0;
      code_q   <= '0;
      en_q     <= '0;
      fs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      first_q  <= first_d;
      active_q <= active_d;
      supp_q   <= supp_d;
      shadow_q <= shadow_d;
      lz_q     <= lz_d;
      pend_q   <= pend_d;
      code_q   <= code_d;
      en_q     <= en_d;
      fs_q     <= fs_d;
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: scoreboarded frame checks of seg7_scan_ctrl with SHOW=4, BLANK=2.
module tb_seg7_scan_ctrl;
  logic        clk = 1'b0;
  logic        reset, load, lz_en;
  logic [15:0] value;
  logic [3:0]  digit_code, digit_en;
  logic        frame_start, pending;
  int          total = 0, bad = 0, n;
  typedef struct {logic [15:0] v; logic [3:0] m;} exp_t;
  exp_t        q[$];
  exp_t        e;
  logic [15:0] gc;
  logic [3:0]  gm, en_exp;
  logic        shape_ok, ab;
  seg7_scan_ctrl #(.NUM_DIGITS(4), .SHOW_CYCLES(4), .BLANK_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .lz_en(lz_en),
    .digit_code(digit_code), .digit_en(digit_en), .frame_start(frame_start), .pending(pending)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] x);
    total++;
    if (g !== x) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, g, x);
    end
  endtask
  task automatic push(input logic [15:0] v, input logic [3:0] m);
    exp_t t;
    t.v = v;
    t.m = m;
    q.push_back(t);
  endtask
  task automatic wait_fs(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!frame_start && cnt < 200);
    if (!frame_start) chk("frame_start_timeout", 0, 1);
  endtask
  initial begin : mon
    forever begin
      @(negedge clk);
      if (frame_start && !reset) begin
        gc = '0;
        gm = '0;
        shape_ok = 1'b1;
        ab = 1'b0;
        for (int t = 0; t < 24; t++) begin
          if (t > 0) @(negedge clk);
          if (reset) begin
            ab = 1'b1;
            break;
          end
          if (t > 0 && frame_start) shape_ok = 1'b0;
          if (t % 6 < 4) begin
            if (t % 6 == 0) begin
              gc[4*(t/6) +: 4] = digit_code;
              gm[t/6] = digit_en[t/6];
            end
            en_exp = gm[t/6] ? 4'(1 << (t/6)) : 4'h0;
            if (digit_en !== en_exp || digit_code !== gc[4*(t/6) +: 4]) shape_ok = 1'b0;
          end else if (digit_en !== 4'h0) shape_ok = 1'b0;
        end
        if (!ab) begin
          if (q.size() == 0) chk("frame_unexpected", 1, 0);
          else begin
            e = q.pop_front();
            chk("frame_codes", gc, e.v);
            chk("frame_mask", gm, e.m);
            chk("frame_shape", shape_ok, 1);
          end
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1'b1; load = 1'b0; value = '0; lz_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_code", digit_code, 0);
    chk("rst_en", digit_en, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_pend", pending, 0);
    push(16'h0000, 4'hF);
    reset = 1'b0;
    wait_fs(n);
    chk("first_show_lat", n, 2);
    chk("first_en", digit_en, 4'b0001);
    chk("first_code", digit_code, 0);
    load = 1'b1; value = 16'h1A3F; lz_en = 1'b0;
    push(16'h1A3F, 4'hF);
    @(negedge clk);
    load = 1'b0;
    chk("pend_after_load", pending, 1);
    wait_fs(n);
    chk("frame_len", n, 23);
    chk("pend_cleared", pending, 0);
    load = 1'b1; value = 16'h0050; lz_en = 1'b1;
    push(16'h0050, 4'b0011);
    @(negedge clk);
    load = 1'b0;
    wait_fs(n);
    load = 1'b1; value = 16'h0000; lz_en = 1'b1;
    push(16'h0000, 4'b0001);
    @(negedge clk);
    load = 1'b0;
    wait_fs(n);
    push(16'h2222, 4'hF);
    repeat (5) @(negedge clk);
    load = 1'b1; value = 16'h1111; lz_en = 1'b0;
    @(negedge clk);
    load = 1'b0;
    chk("pend_mid", pending, 1);
    repeat (2) @(negedge clk);
    load = 1'b1; value = 16'h2222;
    @(negedge clk);
    load = 1'b0;
    wait_fs(n);
    chk("pend_after_last_wins", pending, 0);
    push(16'h4444, 4'hF);
    repeat (5) @(negedge clk);
    load = 1'b1; value = 16'h4444;
    @(negedge clk);
    load = 1'b0;
    repeat (17) @(negedge clk);
    load = 1'b1; value = 16'h3333;
    push(16'h3333, 4'hF);
    wait_fs(n);
    load = 1'b0;
    chk("boundary_lat", n, 1);
    chk("pend_boundary_load", pending, 1);
    wait_fs(n);
    chk("frame_len2", n, 24);
    chk("pend_after_boundary", pending, 0);
    wait_fs(n);
    repeat (5) @(negedge clk);
    load = 1'b1; value = 16'h5555;
    @(negedge clk);
    load = 1'b0;
    chk("pend_before_rst", pending, 1);
    repeat (7) @(negedge clk);
    chk("mid_show_en", digit_en, 4'b0100);
    chk("mid_show_code", digit_code, 3);
    reset = 1'b1;
    push(16'h0000, 4'hF);
    @(negedge clk);
    chk("abort_en", digit_en, 0);
    chk("abort_code", digit_code, 0);
    chk("abort_fs", frame_start, 0);
    chk("abort_pend", pending, 0);
    @(negedge clk);
    reset = 1'b0;
    wait_fs(n);
    chk("restart_lat", n, 2);
    chk("restart_en", digit_en, 4'b0001);
    chk("restart_code", digit_code, 0);
    repeat (25) @(negedge clk);
    chk("sb_drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
